// File: rtl/cycle_meter_ctrl_pkg.sv
// Shared definitions for the cycle meter controller: state encoding and default width.
package cycle_meter_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

endpackage

// File: rtl/cycle_meter_ctrl_if.sv
// Sequencer-to-meter bus: measurement control inputs and registered result outputs.
interface cycle_meter_ctrl_if
  import cycle_meter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic             stop;
  logic             ack;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] timeout_limit;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [WIDTH-1:0] cycles;

  modport master (
    output start, stop, ack, preset, timeout_limit,
    input  busy, valid, timeout, cycles
  );

  modport slave (
    input  start, stop, ack, preset, timeout_limit,
    output busy, valid, timeout, cycles
  );

endinterface

// File: rtl/cycle_meter_ctrl_counter_load.sv
// Loadable up-counter: synchronous clear beats load, load beats increment.
module counter_load #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             up,
  input  logic             w,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (cl) begin
      q_d = '0;
    end else if (w) begin
      q_d = d;
    end else if (up) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cycle_meter_ctrl.sv
// Sequences a loadable counter to measure start-to-stop cycles, with timeout
// and a valid/ack result handshake.
module cycle_meter_ctrl
  import cycle_meter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  cycle_meter_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cycles_q, cycles_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_load;
  logic             cnt_up;
  logic             tmo_hit;

  counter_load #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .cl  (rst),
    .up  (cnt_up),
    .w   (cnt_load),
    .d   (bus.preset),
    .q   (cnt)
  );

  // A zero limit disables the timeout; compare is plain unsigned.
  assign tmo_hit = (bus.timeout_limit != '0) && (cnt >= bus.timeout_limit);

  // Start is accepted in every state, so it directly drives the counter load.
  assign cnt_load = bus.start;
  assign cnt_up   = (state_q == ST_RUN) && !bus.stop && !tmo_hit;

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else if (bus.stop) begin
          cycles_d = cnt;
          state_d  = ST_DONE;
        end else if (tmo_hit) begin
          cycles_d = cnt;
          state_d  = ST_TMO;
        end
      end
      ST_DONE, ST_TMO: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else if (bus.ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags are decoded from the next state so they register alongside it.
    busy_d    = (state_d == ST_RUN);
    valid_d   = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cycles_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.cycles  = cycles_q;

endmodule

// File: doc/cycle_meter_ctrl.md
Name: cycle_meter_ctrl

Overview:
Controller that sequences a loadable up-counter to measure the cycle count between a start event and a stop event, e.g. the latency of an SD/SPI command under test. It loads a preset, runs the counter, stops it on stop or timeout, and holds the result with a valid/ack handshake. It sits between the test sequencer and the result register bank of the measurement system.

Parameters:
WIDTH, 32, width of counter, preset, limit and result.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin (or restart) a measurement; 1-cycle pulse or level, sampled each edge.
stop  in  1  end-of-measurement event, honoured only in RUN.
ack  in  1  consumer accepts result; clears valid/timeout.
preset  in  WIDTH  value loaded into counter on accepted start.
timeout_limit  in  WIDTH  timeout threshold; 0 disables timeout.
busy  out  1  high while in RUN.
valid  out  1  result ready (stop-terminated measurement).
timeout  out  1  result ready (timeout-terminated measurement).
cycles  out  WIDTH  captured count.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counter cleared, busy=0, valid=0, timeout=0, cycles=0. Reset overrides all other inputs, including mid-RUN.
- States: IDLE, RUN, DONE (valid=1), TMO (timeout=1).
- IDLE: start=1 -> counter loaded with preset (load, not increment), next state RUN; stop/ack ignored.
- RUN: busy=1. Each edge, priority order: start=1 -> reload preset, stay RUN (restart). Else stop=1 -> cycles<=q, next DONE, counter holds. Else timeout_limit!=0 and q>=timeout_limit -> cycles<=q, next TMO. Else q<=q+1.
- Timing: start sampled at edge E0 gives q=preset after E0. Stop sampled at edge E0+n (n>=1) gives cycles=preset+n-1, and valid=1 after that edge. Zero-latency cost: 1 cycle of start-to-RUN.
- Simultaneous stop and timeout condition: stop wins (DONE).
- preset>=timeout_limit (limit!=0): TMO on the first RUN edge, cycles=preset.
- Wrap-around: with limit=0, counter wraps 2^WIDTH-1 -> 0 modulo 2^WIDTH. Unsigned compare, no saturation.
- DONE/TMO: cycles and flag held stable. start=1 -> clear flag, reload preset, RUN (start has priority over ack). Else ack=1 -> clear flag, IDLE. cycles is retained until the next capture.
- valid and timeout are never both 1. busy is never 1 together with either.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2, TMO=2'd3) and WIDTH default.
- One sub-module: the team's existing counter_load (clk, cl, up, w, d, q) instantiated as the datapath.
  - cl is driven by rst.
  - w is driven by the accepted start.
  - up is driven by RUN & ~stop & ~timeout-condition.
- The controller contains only the FSM, compare and capture register.

Test Plan:
- Reset mid-RUN: start with preset=0, run 5 cycles, assert rst -> next edge busy=0, valid=0, timeout=0, cycles=0, state IDLE.
- Basic measure: preset=0, limit=0, start at E0, stop at E0+4 -> cycles=3, valid=1, busy=0. Hold 3 cycles (stable), then ack -> valid=0.
- Preset offset and timeout: preset=100, limit=110, no stop -> timeout=1, cycles=110, valid=0. With limit=100 -> timeout on first RUN edge, cycles=100.
- Simultaneous: preset=0, limit=3, stop sampled on the edge where q=3 -> valid=1, timeout=0, cycles=3.
- Restart and priority:
  - start again at E0+3 during RUN, stop 2 edges later -> cycles=preset+1.
  - In DONE, start and ack together -> RUN, valid=0.
- Wrap: preset=32'hFFFF_FFFE, limit=0, stop at E0+4 -> cycles=32'h0000_0001, valid=1.
